// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT0 block receiver: FSM states, register map,
// status bit positions and the CRC16 polynomial.
package sd_dat_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        DATA       = 3'd2,
        CRC        = 3'd3,
        END        = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_FIFO  = 2'd1;
    localparam logic [1:0] ADDR_COUNT = 2'd2;
    localparam logic [1:0] ADDR_RSVD  = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_CRC_ERR   = 2;
    localparam int STAT_TIMEOUT   = 3;
    localparam int STAT_LEVEL_LSB = 8;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT (init 0), MSB first; clr has priority over en.
module sd_crc16
    import sd_dat_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = din ^ crc_q[15];
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_dat_rx.sv
// SD DAT0 block receiver with Avalon-MM slave registers and a word FIFO that
// stalls the card clock when full. Define SD_DAT_RX_CRC_EN to check the CRC16.
module sd_dat_rx
    import sd_dat_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    input  logic        sd_dat
);

    localparam int BITS   = 8 * BLOCK_BYTES;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(BITS);
    localparam int WCNT_W = $clog2(BLOCK_BYTES / 4 + 1);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(BITS - 1);
    localparam logic [BIT_W-1:0] CRC_LAST  = BIT_W'(15);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    state_t              state_q, state_d;
    logic                dat_q;
    logic                sd_clk_q, sd_clk_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]         shift_q, shift_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                done_q, done_d;
    logic                crc_err_q, crc_err_d;
    logic                timeout_q, timeout_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [31:0]         readdata_q, readdata_d;
    logic [31:0]         fifo_mem [FIFO_DEPTH];

    logic        wr_en, rd_en, ctrl_wr;
    logic        abort_req, start_req, flush;
    logic        busy, fifo_full, fifo_empty, pop, push;
    logic        stall, sd_rise, crc_bad;
    logic [31:0] push_word, status_word;
    logic        unused_wdata;

    assign wr_en      = chipselect && !write_n;
    assign rd_en      = chipselect && !read_n;
    assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
    assign abort_req  = ctrl_wr && writedata[CTRL_ABORT];
    assign start_req  = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_ABORT] && !busy;
    assign flush      = abort_req || start_req;
    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);
    assign pop        = rd_en && (address == ADDR_FIFO) && !fifo_empty;
    assign push_word  = {shift_q[30:0], dat_q};
    assign unused_wdata = ^writedata[31:2];

    // A pop in the same cycle frees the slot, so the stalled edge may proceed.
    assign stall   = (state_q == DATA) && !sd_clk_q && fifo_full && !pop;
    assign sd_rise = busy && !stall && !sd_clk_q && (div_cnt_q == DIV_LAST);

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (abort_req) begin
            state_d = IDLE;
        end else if (start_req) begin
            state_d = WAIT_START;
        end else if (sd_rise) begin
            case (state_q)
                WAIT_START: begin
                    if (!dat_q) begin
                        state_d = DATA;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_d = DONE;
                    end
                end
                DATA:    if (bit_cnt_q == DATA_LAST) state_d = CRC;
                CRC:     if (bit_cnt_q == CRC_LAST) state_d = END;
                END:     state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        case (state_q)
            WAIT_START, DATA, CRC, END: busy = 1'b1;
            default:                    busy = 1'b0;
        endcase
    end

    // Card clock divider; parked low whenever the FSM is not receiving.
    always_comb begin
        div_cnt_d = div_cnt_q;
        sd_clk_d  = sd_clk_q;
        if (flush || !busy) begin
            div_cnt_d = '0;
            sd_clk_d  = 1'b0;
        end else if (!stall) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                sd_clk_d  = !sd_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        word_cnt_d = word_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        done_d     = done_q;
        crc_err_d  = crc_err_q;
        timeout_d  = timeout_q;
        push       = 1'b0;
        if (abort_req) begin
            done_d    = 1'b0;
            crc_err_d = 1'b0;
            timeout_d = 1'b0;
        end else if (start_req) begin
            done_d     = 1'b0;
            crc_err_d  = 1'b0;
            timeout_d  = 1'b0;
            word_cnt_d = '0;
            bit_cnt_d  = '0;
            tmo_cnt_d  = '0;
        end else if (sd_rise) begin
            shift_d = push_word;
            case (state_q)
                WAIT_START: begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    bit_cnt_d = '0;
                    if (dat_q && (tmo_cnt_q == TMO_LAST)) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
                DATA: begin
                    bit_cnt_d = (bit_cnt_q == DATA_LAST) ? '0 : bit_cnt_q + 1'b1;
                    if (bit_cnt_q[4:0] == 5'h1f) begin
                        push       = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
                CRC: begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                END: begin
                    done_d = 1'b1;
                    if (!dat_q || crc_bad) begin
                        crc_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SD_DAT_RX_CRC_EN
    logic [15:0] crc_calc;

    sd_crc16 u_crc (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (start_req),
        .en    (sd_rise && (state_q == DATA)),
        .din   (dat_q),
        .crc   (crc_calc)
    );

    // At END the low half of the shifter holds the 16 received CRC bits.
    assign crc_bad = (crc_calc != shift_q[15:0]);
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_BUSY]    = busy;
        status_word[STAT_DONE]    = done_q;
        status_word[STAT_CRC_ERR] = crc_err_q;
        status_word[STAT_TIMEOUT] = timeout_q;
        status_word[STAT_LEVEL_LSB +: 5] = 5'(level_q);
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                ADDR_CTRL:  readdata_d = status_word;
                ADDR_FIFO:  readdata_d = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_q];
                ADDR_COUNT: readdata_d = 32'(word_cnt_q);
                default:    readdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dat_q      <= 1'b1;
            sd_clk_q   <= 1'b0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            readdata_q <= '0;
        end else begin
            dat_q      <= sd_dat;
            sd_clk_q   <= sd_clk_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            word_cnt_q <= word_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            timeout_q  <= timeout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign sd_clk   = sd_clk_q;

endmodule

// File: tb/tb_sd_dat_rx.sv
// Scoreboard bench for sd_dat_rx: a card model feeds DAT0 frames, expected
// FIFO words are queued when a frame is built and compared as they are read.
module tb_sd_dat_rx;

    localparam int CLK_DIV        = 2;
    localparam int BLOCK_BYTES    = 16;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int FIFO_DEPTH     = 2;
    localparam int WORDS          = BLOCK_BYTES / 4;

`ifdef SD_DAT_RX_CRC_EN
    localparam logic CRC_EN = 1'b1;
`else
    localparam logic CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        sd_clk;
    logic        sd_dat = 1'b1;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          edge_cnt = 0;
    logic        sd_clk_prev = 1'b0;
    bit          card_q [$];
    logic [31:0] exp_q [$];
    logic [7:0]  blk [BLOCK_BYTES];

    sd_dat_rx #(
        .CLK_DIV        (CLK_DIV),
        .BLOCK_BYTES    (BLOCK_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sd_clk     (sd_clk),
        .sd_dat     (sd_dat)
    );

    always #5 clk = ~clk;

    // Card model: presents the head bit, advances after each sd_clk rising edge.
    always @(negedge clk) begin
        if (sd_clk && !sd_clk_prev) begin
            edge_cnt++;
            if (card_q.size() != 0) void'(card_q.pop_front());
        end
        sd_clk_prev = sd_clk;
        sd_dat = (card_q.size() != 0) ? card_q[0] : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
    endfunction

    task automatic load_frame(input bit flip_crc, input bit bad_end);
        logic [15:0] crc;
        crc = 16'h0;
        card_q.delete();
        card_q.push_back(1'b0);
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            for (int b = 7; b >= 0; b--) begin
                card_q.push_back(blk[i][b]);
                crc = crc16_step(crc, blk[i][b]);
            end
        end
        if (flip_crc) crc[5] = ~crc[5];
        for (int b = 15; b >= 0; b--) card_q.push_back(crc[b]);
        card_q.push_back(!bad_end);
        for (int w = 0; w < WORDS; w++) begin
            exp_q.push_back({blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]});
        end
    endtask

    task automatic drain_block(output logic [31:0] st);
        logic [31:0] d;
        st = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            bus_read(2'd0, st);
            if (st[12:8] != 5'd0) begin
                bus_read(2'd1, d);
                if (exp_q.size() != 0) check("fifo_word", d, exp_q.pop_front());
                else check("sb_words_left", 32'(exp_q.size()), 32'd1);
            end else if (st[1]) begin
                break;
            end
        end
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] d;
        int          e0;

        // Reset
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_sd_clk", 32'(sd_clk), 32'h0);
        bus_read(2'd0, st);
        check("reset_status", st, 32'h0);
        bus_read(2'd2, d);
        check("reset_count", d, 32'h0);

        // Start and abort together: abort wins, FSM stays idle
        bus_write(2'd0, 32'h3);
        bus_read(2'd0, st);
        check("start_abort_status", st, 32'h0);

        // Normal block
        for (int i = 0; i < BLOCK_BYTES; i++) blk[i] = 8'(i + 1);
        load_frame(1'b0, 1'b0);
        bus_write(2'd0, 32'h1);
        drain_block(st);
        check("normal_status", st, 32'h2);
        bus_read(2'd2, d);
        check("normal_count", d, 32'(WORDS));
        bus_read(2'd1, d);
        check("empty_fifo_read", d, 32'h0);
        bus_read(2'd0, st);
        bus_read(2'd3, d);
        check("addr3_read", d, 32'h0);

        // Flipped CRC bit
        for (int i = 0; i < BLOCK_BYTES; i++) blk[i] = 8'($urandom_range(0, 255));
        load_frame(1'b1, 1'b0);
        bus_write(2'd0, 32'h1);
        drain_block(st);
        check("crc_flip_status", st, 32'h2 | {29'h0, CRC_EN, 2'b00});

        // Bad end bit
        for (int i = 0; i < BLOCK_BYTES; i++) blk[i] = 8'(8'hA5 ^ 8'(i * 17));
        load_frame(1'b0, 1'b1);
        bus_write(2'd0, 32'h1);
        drain_block(st);
        check("bad_end_status", st, 32'h6);

        // Timeout: DAT0 idle high
        card_q.delete();
        e0 = edge_cnt;
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 500; i++) begin
            bus_read(2'd0, st);
            if (st[1]) break;
        end
        check("timeout_status", st, 32'hA);
        repeat (20) @(negedge clk);
        check("timeout_edges", 32'(edge_cnt - e0), 32'(TIMEOUT_CYCLES));
        bus_read(2'd2, d);
        check("timeout_count", d, 32'h0);

        // Stall: no FIFO reads until it fills
        for (int i = 0; i < BLOCK_BYTES; i++) blk[i] = 8'(8'hF0 - 8'(i));
        load_frame(1'b0, 1'b0);
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 1000; i++) begin
            bus_read(2'd0, st);
            if (st[12:8] == 5'(FIFO_DEPTH)) break;
        end
        check("stall_status", st, 32'h1 | (32'(FIFO_DEPTH) << 8));
        repeat (4) @(negedge clk);
        e0 = edge_cnt;
        repeat (40) @(negedge clk);
        check("stall_edges", 32'(edge_cnt - e0), 32'h0);
        check("stall_sd_clk", 32'(sd_clk), 32'h0);
        bus_read(2'd1, d);
        check("stall_pop", d, exp_q.pop_front());
        repeat (3 * CLK_DIV) @(negedge clk);
        check("stall_resumed", 32'(edge_cnt != e0), 32'h1);
        drain_block(st);
        check("stall_final_status", st, 32'h2);

        // Abort mid-DATA with one word buffered
        for (int i = 0; i < BLOCK_BYTES; i++) blk[i] = 8'(8'h3C + 8'(i));
        load_frame(1'b0, 1'b0);
        e0 = edge_cnt;
        bus_write(2'd0, 32'h1);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (edge_cnt - e0 >= 40) break;
        end
        check("abort_reached_data", 32'(edge_cnt - e0 >= 40), 32'h1);
        bus_read(2'd0, st);
        check("pre_abort_status", st, 32'h101);
        bus_write(2'd0, 32'h2);
        check("abort_sd_clk", 32'(sd_clk), 32'h0);
        card_q.delete();
        exp_q.delete();
        bus_read(2'd0, st);
        check("abort_status", st, 32'h0);

        // Reset asserted mid-block
        for (int i = 0; i < BLOCK_BYTES; i++) blk[i] = 8'(i * 3);
        load_frame(1'b0, 1'b0);
        bus_write(2'd0, 32'h1);
        repeat (60) @(negedge clk);
        bus_read(2'd0, st);
        reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_sd_clk", 32'(sd_clk), 32'h0);
        card_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd0, st);
        check("midreset_status", st, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
